acc_tile_sched: RTL and testbench

Sequencer for the FIFO-based partial-sum accumulator (`shift_accumulator`). It takes one tile's partial-sum stream from the PE array as a sequence of passes and drives the accumulator's `input_valid`/`is_init_data`/`calc_done` so pass 0 initialises and later passes accumulate. Between passes it inserts the bubble the accumulator needs to rewind its write pointer. After the last pass it sweeps `read_ptr` to drain the results onto a valid/ready output stream.

---
 rtl/acc_tile_sched_pkg.sv | 21 ++
 rtl/acc_tile_counter.sv | 60 ++++++
 rtl/acc_tile_sched.sv | 179 +++++++++++++++++
 tb/tb_acc_tile_sched.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_tile_sched_pkg.sv
// Shared types and width helpers for the accumulator tile sequencer.
package acc_tile_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_BIAS  = 3'd1,
    ST_PASS  = 3'd2,
    ST_GAP   = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  function automatic int ACC_PTR_W(input int stage_num);
    return (stage_num > 1) ? $clog2(stage_num) : 1;
  endfunction

  // Length fields must hold STAGE_NUM itself, hence the extra bit.
  function automatic int ACC_LEN_W(input int stage_num);
    return $clog2(stage_num) + 1;
  endfunction

endpackage

// File: rtl/acc_tile_counter.sv
// Beat and pass counters with terminal flags; the beat counter doubles as the drain index.
module acc_tile_counter #(
  parameter int LEN_W  = 5,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              beat_inc_i,
  input  logic              pass_inc_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [PASS_W-1:0] passes_i,
  output logic [LEN_W-1:0]  beat_o,
  output logic [PASS_W-1:0] pass_o,
  output logic              beat_last_o,
  output logic              pass_last_o,
  output logic              passes_done_o
);

  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [PASS_W-1:0] pass_q, pass_d;

  assign beat_last_o   = (beat_q == (len_i - LEN_W'(1)));
  assign pass_last_o   = (pass_q == (passes_i - PASS_W'(1)));
  assign passes_done_o = (pass_q == passes_i);
  assign beat_o        = beat_q;
  assign pass_o        = pass_q;

  // Beat wraps to zero on its terminal count so each pass and the drain start at 0.
  always_comb begin
    beat_d = beat_q;
    pass_d = pass_q;
    if (clr_i) begin
      beat_d = {LEN_W{1'b0}};
      pass_d = {PASS_W{1'b0}};
    end else begin
      if (beat_inc_i) begin
        beat_d = beat_last_o ? {LEN_W{1'b0}} : (beat_q + LEN_W'(1));
      end else begin
        beat_d = beat_q;
      end
      if (pass_inc_i) begin
        pass_d = pass_q + PASS_W'(1);
      end else begin
        pass_d = pass_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q <= {LEN_W{1'b0}};
      pass_q <= {PASS_W{1'b0}};
    end else begin
      beat_q <= beat_d;
      pass_q <= pass_d;
    end
  end

endmodule

// File: rtl/acc_tile_sched.sv
// Pass/gap/drain sequencer for the FIFO-based partial-sum accumulator.
// Optional bias-init pass enabled by defining ACC_TILE_SCHED_BIAS_EN.
module acc_tile_sched
  import acc_tile_sched_pkg::*;
#(
  parameter int STAGE_NUM  = 16,
  parameter int DATA_WIDTH = 32,
  parameter int PASS_W     = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_i,
  input  logic [ACC_LEN_W(STAGE_NUM)-1:0]   cfg_len_i,
  input  logic [PASS_W-1:0]                 cfg_passes_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              cfg_err_o,
  input  logic [DATA_WIDTH-1:0]             in_data_i,
  input  logic                              in_valid_i,
  output logic                              in_ready_o,
`ifdef ACC_TILE_SCHED_BIAS_EN
  input  logic [DATA_WIDTH-1:0]             bias_data_i,
  input  logic                              bias_valid_i,
  output logic                              bias_ready_o,
`endif
  output logic [DATA_WIDTH-1:0]             acc_data_o,
  output logic                              acc_valid_o,
  output logic                              acc_init_o,
  output logic                              acc_done_o,
  output logic [ACC_PTR_W(STAGE_NUM)-1:0]   acc_read_ptr_o,
  input  logic [DATA_WIDTH-1:0]             acc_data_i,
  output logic [DATA_WIDTH-1:0]             out_data_o,
  output logic                              out_valid_o,
  input  logic                              out_ready_i
);

  localparam int LEN_W = ACC_LEN_W(STAGE_NUM);
  localparam int PTR_W = ACC_PTR_W(STAGE_NUM);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  cfg_len_q, cfg_len_d;
  logic [PASS_W-1:0] cfg_passes_q, cfg_passes_d;
  logic              cfg_err_q, cfg_err_d;

  logic              cfg_ok_s;
  logic              cnt_clr_s, beat_inc_s, pass_inc_s;
  logic [LEN_W-1:0]  beat_s;
  logic [PASS_W-1:0] pass_s;
  logic              beat_last_s, pass_last_s, passes_done_s;

  acc_tile_counter #(
    .LEN_W  (LEN_W),
    .PASS_W (PASS_W)
  ) u_cnt (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr_i         (cnt_clr_s),
    .beat_inc_i    (beat_inc_s),
    .pass_inc_i    (pass_inc_s),
    .len_i         (cfg_len_q),
    .passes_i      (cfg_passes_q),
    .beat_o        (beat_s),
    .pass_o        (pass_s),
    .beat_last_o   (beat_last_s),
    .pass_last_o   (pass_last_s),
    .passes_done_o (passes_done_s)
  );

  assign cfg_ok_s = (cfg_len_i != {LEN_W{1'b0}}) && (cfg_len_i <= LEN_W'(STAGE_NUM)) &&
                    (cfg_passes_i != {PASS_W{1'b0}});

`ifdef ACC_TILE_SCHED_BIAS_EN
  assign acc_data_o = (state_q == ST_BIAS) ? bias_data_i : in_data_i;
`else
  assign acc_data_o = in_data_i;
`endif
  assign out_data_o = acc_data_i;
  assign busy_o     = (state_q != ST_IDLE);
  assign cfg_err_o  = cfg_err_q;

  always_comb begin
    state_d        = state_q;
    cfg_len_d      = cfg_len_q;
    cfg_passes_d   = cfg_passes_q;
    cfg_err_d      = 1'b0;
    cnt_clr_s      = 1'b0;
    beat_inc_s     = 1'b0;
    pass_inc_s     = 1'b0;
    in_ready_o     = 1'b0;
    acc_valid_o    = 1'b0;
    acc_init_o     = 1'b0;
    acc_done_o     = 1'b0;
    out_valid_o    = 1'b0;
    done_o         = 1'b0;
    acc_read_ptr_o = {PTR_W{1'b0}};
`ifdef ACC_TILE_SCHED_BIAS_EN
    bias_ready_o   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_i && cfg_ok_s) begin
          cfg_len_d    = cfg_len_i;
          cfg_passes_d = cfg_passes_i;
          cnt_clr_s    = 1'b1;
`ifdef ACC_TILE_SCHED_BIAS_EN
          state_d      = ST_BIAS;
`else
          state_d      = ST_PASS;
`endif
        end else begin
          cfg_err_d = start_i;
        end
      end
`ifdef ACC_TILE_SCHED_BIAS_EN
      ST_BIAS: begin
        bias_ready_o = 1'b1;
        if (bias_valid_i) begin
          acc_valid_o = 1'b1;
          acc_init_o  = 1'b1;
          beat_inc_s  = 1'b1;
          state_d     = beat_last_s ? ST_GAP : ST_BIAS;
        end else begin
          state_d = ST_BIAS;
        end
      end
`endif
      ST_PASS: begin
        in_ready_o = 1'b1;
        if (in_valid_i) begin
          acc_valid_o = 1'b1;
`ifdef ACC_TILE_SCHED_BIAS_EN
          acc_init_o  = 1'b0;
`else
          acc_init_o  = (pass_s == {PASS_W{1'b0}});
`endif
          acc_done_o  = beat_last_s && pass_last_s;
          beat_inc_s  = 1'b1;
          pass_inc_s  = beat_last_s;
          state_d     = beat_last_s ? ST_GAP : ST_PASS;
        end else begin
          state_d = ST_PASS;
        end
      end
      // Valid low for this one cycle lets the accumulator rewind its write pointer.
      ST_GAP: begin
        state_d = passes_done_s ? ST_DRAIN : ST_PASS;
      end
      ST_DRAIN: begin
        out_valid_o    = 1'b1;
        acc_read_ptr_o = beat_s[PTR_W-1:0];
        if (out_ready_i) begin
          beat_inc_s = 1'b1;
          done_o     = beat_last_s;
          state_d    = beat_last_s ? ST_IDLE : ST_DRAIN;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cfg_len_q    <= {LEN_W{1'b0}};
      cfg_passes_q <= {PASS_W{1'b0}};
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_len_q    <= cfg_len_d;
      cfg_passes_q <= cfg_passes_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_acc_tile_sched.sv
// Directed bench for acc_tile_sched with a behavioural saturating shift-accumulator model.
// Covers the ACC_TILE_SCHED_BIAS_EN build when that macro is defined.
module tb_acc_tile_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [4:0]  cfg_len_i = 5'd0;
  logic [7:0]  cfg_passes_i = 8'd0;
  logic        busy_o, done_o, cfg_err_o;
  logic [31:0] in_data_i = 32'd0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] acc_data_o;
  logic        acc_valid_o, acc_init_o, acc_done_o;
  logic [3:0]  acc_read_ptr_o;
  logic [31:0] acc_data_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
`ifdef ACC_TILE_SCHED_BIAS_EN
  logic [31:0] bias_data_i = 32'd0;
  logic        bias_valid_i = 1'b0;
  logic        bias_ready_o;
`endif

  int total = 0;
  int bad = 0;

  logic [31:0] mem [16];
  logic [3:0]  wp = 4'd0;
  logic        prev_v = 1'b0;
  logic [31:0] va [16];
  logic [31:0] ve [16];

  always #5 clk = ~clk;

  acc_tile_sched dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cfg_len_i(cfg_len_i),
    .cfg_passes_i(cfg_passes_i), .busy_o(busy_o), .done_o(done_o), .cfg_err_o(cfg_err_o),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
`ifdef ACC_TILE_SCHED_BIAS_EN
    .bias_data_i(bias_data_i), .bias_valid_i(bias_valid_i), .bias_ready_o(bias_ready_o),
`endif
    .acc_data_o(acc_data_o), .acc_valid_o(acc_valid_o), .acc_init_o(acc_init_o),
    .acc_done_o(acc_done_o), .acc_read_ptr_o(acc_read_ptr_o), .acc_data_i(acc_data_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
  );

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else return s[31:0];
  endfunction

  // Accumulator model: write on valid, rewind write pointer when valid falls.
  always @(posedge clk) begin
    if (acc_valid_o) begin
      mem[wp] <= acc_init_o ? acc_data_o : sat_add(mem[wp], acc_data_o);
      wp      <= wp + 4'd1;
    end else if (prev_v) begin
      wp <= 4'd0;
    end
    prev_v <= acc_valid_o;
  end
  assign acc_data_i = mem[acc_read_ptr_o];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_tile(input int len, input int passes);
    start_i = 1'b1; cfg_len_i = 5'(len); cfg_passes_i = 8'(passes);
    tick();
    start_i = 1'b0;
    chk("busy_after_start", {31'd0, busy_o}, 32'd1);
  endtask

  task automatic send_pass(input int len, input bit first, input bit last);
    for (int i = 0; i < len; i++) begin
      in_valid_i = 1'b1; in_data_i = va[i];
      #1;
      chk("pass_in_ready", {31'd0, in_ready_o}, 32'd1);
      chk("pass_acc_valid", {31'd0, acc_valid_o}, 32'd1);
      chk("pass_acc_data", acc_data_o, va[i]);
      chk("pass_acc_init", {31'd0, acc_init_o}, {31'd0, first});
      chk("pass_acc_done", {31'd0, acc_done_o}, {31'd0, last && (i == len - 1)});
      tick();
    end
    in_valid_i = 1'b0;
    #1;
    chk("gap_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("gap_acc_valid", {31'd0, acc_valid_o}, 32'd0);
    tick();
  endtask

  // Bit c of ready_pat gives out_ready for drain cycle c (1 beyond bit 31).
  task automatic drain(input int len, input logic [31:0] ready_pat);
    int idx = 0;
    int dones = 0;
    int cyc = 0;
    while (idx < len && cyc < 100) begin
      out_ready_i = (cyc < 32) ? ready_pat[cyc] : 1'b1;
      #1;
      chk("drain_valid", {31'd0, out_valid_o}, 32'd1);
      chk("drain_ptr", {28'd0, acc_read_ptr_o}, 32'(idx));
      chk("drain_data", out_data_o, ve[idx]);
      chk("drain_done", {31'd0, done_o}, {31'd0, out_ready_i && (idx == len - 1)});
      if (done_o) dones++;
      if (out_ready_i) idx++;
      cyc++;
      tick();
    end
    out_ready_i = 1'b0;
    chk("drain_done_count", 32'(dones), 32'd1);
    chk("idle_busy", {31'd0, busy_o}, 32'd0);
    chk("idle_out_valid", {31'd0, out_valid_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err_o}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready_o}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    chk("rst_acc_flags", {29'd0, acc_valid_o, acc_init_o, acc_done_o}, 32'd0);
    chk("rst_read_ptr", {28'd0, acc_read_ptr_o}, 32'd0);
    rst_n = 1'b1;
    tick();

`ifdef ACC_TILE_SCHED_BIAS_EN
    // Bias 10..40, two passes of ones -> 12,22,32,42.
    start_tile(4, 2);
    for (int i = 0; i < 4; i++) begin
      bias_valid_i = 1'b1; bias_data_i = 32'(10 * (i + 1));
      #1;
      chk("bias_ready", {31'd0, bias_ready_o}, 32'd1);
      chk("bias_init", {31'd0, acc_init_o}, 32'd1);
      chk("bias_data", acc_data_o, 32'(10 * (i + 1)));
      tick();
    end
    bias_valid_i = 1'b0;
    #1;
    chk("bias_gap_valid", {31'd0, acc_valid_o}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) va[i] = 32'd1;
    send_pass(4, 1'b0, 1'b0);
    send_pass(4, 1'b0, 1'b1);
    ve[0] = 32'd12; ve[1] = 32'd22; ve[2] = 32'd32; ve[3] = 32'd42;
    drain(4, 32'hFFFF_FFFF);
`else
    // len=4, passes=3, inputs 1..4; drain with ready 1,0,0,1 -> 3,6,9,12.
    start_tile(4, 3);
    for (int i = 0; i < 4; i++) va[i] = 32'(i + 1);
    send_pass(4, 1'b1, 1'b0);
    send_pass(4, 1'b0, 1'b0);
    send_pass(4, 1'b0, 1'b1);
    ve[0] = 32'd3; ve[1] = 32'd6; ve[2] = 32'd9; ve[3] = 32'd12;
    drain(4, 32'hFFFF_FFF9);

    // Full depth with saturation.
    start_tile(16, 2);
    for (int i = 0; i < 16; i++) begin
      va[i] = 32'h7FFF_FFFF;
      ve[i] = 32'h7FFF_FFFF;
    end
    send_pass(16, 1'b1, 1'b0);
    send_pass(16, 1'b0, 1'b1);
    drain(16, 32'hFFFF_FFFF);

    // len=1, 7 then 8 -> 15; a bad start while busy must be ignored.
    start_tile(1, 2);
    start_i = 1'b1; cfg_len_i = 5'd0;
    va[0] = 32'd7;
    send_pass(1, 1'b1, 1'b0);
    start_i = 1'b0;
    chk("busy_start_ignored", {31'd0, cfg_err_o}, 32'd0);
    chk("busy_still", {31'd0, busy_o}, 32'd1);
    va[0] = 32'd8;
    send_pass(1, 1'b0, 1'b1);
    ve[0] = 32'd15;
    drain(1, 32'hFFFF_FFFF);

    // Illegal configurations.
    start_i = 1'b1; cfg_len_i = 5'd0; cfg_passes_i = 8'd1;
    tick();
    start_i = 1'b0;
    chk("err_len0_pulse", {31'd0, cfg_err_o}, 32'd1);
    chk("err_len0_idle", {31'd0, busy_o}, 32'd0);
    tick();
    chk("err_len0_clear", {31'd0, cfg_err_o}, 32'd0);
    start_i = 1'b1; cfg_len_i = 5'd17; cfg_passes_i = 8'd1;
    tick();
    start_i = 1'b0;
    chk("err_len17_pulse", {31'd0, cfg_err_o}, 32'd1);
    chk("err_len17_idle", {31'd0, busy_o}, 32'd0);
    start_i = 1'b1; cfg_len_i = 5'd4; cfg_passes_i = 8'd0;
    tick();
    start_i = 1'b0;
    chk("err_pass0_pulse", {31'd0, cfg_err_o}, 32'd1);
    chk("err_pass0_idle", {31'd0, in_ready_o}, 32'd0);
    tick();

    // Reset mid-pass, then a fresh tile must not see stale data.
    start_tile(4, 2);
    in_valid_i = 1'b1; in_data_i = 32'd99;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    chk("midrst_acc_valid", {31'd0, acc_valid_o}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready_o}, 32'd0);
    in_valid_i = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_tile(2, 1);
    va[0] = 32'd5; va[1] = 32'd6;
    send_pass(2, 1'b1, 1'b1);
    ve[0] = 32'd5; ve[1] = 32'd6;
    drain(2, 32'hFFFF_FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
